// File: rtl/forwarding_network.sv
// Operand forwarding network: resolves consumer source operands from MEM, WB,
// a short retire history or the register file, and raises load-use stalls.
module forwarding_network #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NSRC   = 2,
    parameter int unsigned HDEPTH = 2,
    parameter int unsigned REGW   = 3,
    parameter int unsigned TMO    = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_valid,
    input  logic                   mem_we,
    input  logic                   mem_is_load,
    input  logic [REGW-1:0]        mem_dest,
    input  logic [WIDTH-1:0]       mem_data,
    input  logic                   mem_data_ready,
    input  logic                   wb_valid,
    input  logic                   wb_we,
    input  logic [REGW-1:0]        wb_dest,
    input  logic [WIDTH-1:0]       wb_data,
    input  logic                   pipe_advance,
    input  logic                   id_advance,
    input  logic [NSRC*REGW-1:0]   src_reg,
    input  logic [NSRC-1:0]        src_used,
    input  logic [NSRC*WIDTH-1:0]  rf_data,
    output logic [NSRC*WIDTH-1:0]  opnd,
    output logic [NSRC*2-1:0]      fwd_src,
    output logic                   stall,
    output logic [15:0]            stall_cnt,
    input  logic                   cnt_clr,
    output logic                   err_tmo
);

    localparam int unsigned CNTW = 16;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        LDSTALL = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNTW-1:0]   r_wait;
    logic [CNTW-1:0]   w_wait_nxt;
    logic [CNTW-1:0]   r_stall_cnt;
    logic              r_err_tmo;

    logic [HDEPTH-1:0] r_hv;
    logic [REGW-1:0]   r_hdest [HDEPTH];
    logic [WIDTH-1:0]  r_hdata [HDEPTH];

    logic              w_mem_wr;
    logic              w_wb_wr;
    logic              w_retire;

    assign w_mem_wr = mem_valid & mem_we;
    assign w_wb_wr  = wb_valid & wb_we;
    assign w_retire = pipe_advance & w_wb_wr;

    // Retire history: entry 0 is the newest write still invisible in rf_data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hv <= '0;
        end else if (id_advance && w_retire) begin
            r_hv       <= HDEPTH'(1);
            r_hdest[0] <= wb_dest;
            r_hdata[0] <= wb_data;
        end else if (id_advance && !pipe_advance) begin
            r_hv <= '0;
        end else if (w_retire && !id_advance) begin
            for (int j = int'(HDEPTH) - 1; j > 0; j--) begin
                r_hv[j]    <= r_hv[j-1];
                r_hdest[j] <= r_hdest[j-1];
                r_hdata[j] <= r_hdata[j-1];
            end
            r_hv[0]    <= 1'b1;
            r_hdest[0] <= wb_dest;
            r_hdata[0] <= wb_data;
        end
    end

    // Operand select; later assignments override, giving MEM > WB > newest history > rf
    always_comb begin
        opnd    = rf_data;
        fwd_src = '0;
        for (int i = 0; i < int'(NSRC); i++) begin
            for (int j = int'(HDEPTH) - 1; j >= 0; j--) begin
                if (r_hv[j] && (r_hdest[j] == src_reg[i*REGW +: REGW])) begin
                    opnd[i*WIDTH +: WIDTH] = r_hdata[j];
                    fwd_src[i*2 +: 2]      = 2'd1;
                end
            end
            if (w_wb_wr && (wb_dest == src_reg[i*REGW +: REGW])) begin
                opnd[i*WIDTH +: WIDTH] = wb_data;
                fwd_src[i*2 +: 2]      = 2'd2;
            end
            if (w_mem_wr && (mem_dest == src_reg[i*REGW +: REGW])) begin
                opnd[i*WIDTH +: WIDTH] = mem_data;
                fwd_src[i*2 +: 2]      = 2'd3;
            end
        end
    end

    // Stall decode works from the match terms only, independent of the operand mux
    always_comb begin
        stall = 1'b0;
        for (int i = 0; i < int'(NSRC); i++) begin
            if (src_used[i] && w_mem_wr && (mem_dest == src_reg[i*REGW +: REGW]) &&
                mem_is_load && !mem_data_ready) begin
                stall = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        case (r_state)
            RUN: begin
                if (stall) begin
                    w_state_nxt = LDSTALL;
                    w_wait_nxt  = '0;
                end
            end
            LDSTALL: begin
                if (stall) begin
                    if (r_wait != {CNTW{1'b1}}) begin
                        w_wait_nxt = r_wait + CNTW'(1);
                    end
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_tmo <= 1'b0;
        end else if (stall && (w_wait_nxt == CNTW'(TMO))) begin
            r_err_tmo <= 1'b1;
        end
    end

    // Clear and a stall in the same cycle count that cycle as the first
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= stall ? CNTW'(1) : '0;
        end else if (stall && (r_stall_cnt != {CNTW{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNTW'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign err_tmo   = r_err_tmo;

endmodule

// File: tb/tb_forwarding_network.sv
// Directed bench for forwarding_network: vector table for operand selection,
// hand sequences for stall, history, timeout and counter corner cases.
module tb_forwarding_network;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned NSRC   = 2;
    localparam int unsigned HDEPTH = 2;
    localparam int unsigned REGW   = 3;
    localparam int unsigned TMO    = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  mem_valid, mem_we, mem_is_load, mem_data_ready;
    logic [REGW-1:0]       mem_dest;
    logic [WIDTH-1:0]      mem_data;
    logic                  wb_valid, wb_we;
    logic [REGW-1:0]       wb_dest;
    logic [WIDTH-1:0]      wb_data;
    logic                  pipe_advance, id_advance, cnt_clr;
    logic [NSRC*REGW-1:0]  src_reg;
    logic [NSRC-1:0]       src_used;
    logic [NSRC*WIDTH-1:0] rf_data;
    logic [NSRC*WIDTH-1:0] opnd;
    logic [NSRC*2-1:0]     fwd_src;
    logic                  stall, err_tmo;
    logic [15:0]           stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    forwarding_network #(
        .WIDTH(WIDTH), .NSRC(NSRC), .HDEPTH(HDEPTH), .REGW(REGW), .TMO(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_is_load(mem_is_load),
        .mem_dest(mem_dest), .mem_data(mem_data), .mem_data_ready(mem_data_ready),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
        .pipe_advance(pipe_advance), .id_advance(id_advance),
        .src_reg(src_reg), .src_used(src_used), .rf_data(rf_data),
        .opnd(opnd), .fwd_src(fwd_src), .stall(stall), .stall_cnt(stall_cnt),
        .cnt_clr(cnt_clr), .err_tmo(err_tmo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mv, mwe, mld;
        logic [2:0]  mdst;
        logic [15:0] mdata;
        logic        mrdy;
        logic        wv, wwe;
        logic [2:0]  wdst;
        logic [15:0] wdata;
        logic [5:0]  src;
        logic [1:0]  used;
        logic [31:0] e_opnd;
        logic [3:0]  e_fwd;
        logic        e_stall;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_valid = 0; mem_we = 0; mem_is_load = 0; mem_dest = '0; mem_data = '0;
        mem_data_ready = 1; wb_valid = 0; wb_we = 0; wb_dest = '0; wb_data = '0;
        pipe_advance = 0; id_advance = 0; cnt_clr = 0;
        src_reg = '0; src_used = '0; rf_data = {16'hBBBB, 16'hAAAA};
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic retire(input logic [2:0] d, input logic [15:0] v, input logic ida);
        wb_valid = 1; wb_we = 1; wb_dest = d; wb_data = v;
        pipe_advance = 1; id_advance = ida;
        tick();
        wb_valid = 0; wb_we = 0; pipe_advance = 0; id_advance = 0;
    endtask

    task automatic load_stall_inputs(input logic rdy);
        mem_valid = 1; mem_we = 1; mem_is_load = 1; mem_dest = 3'd2;
        mem_data = 16'h5555; mem_data_ready = rdy;
        src_reg = {3'd2, 3'd1}; src_used = 2'b10;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{0,0,0,3'd0,16'h0000,1, 0,0,3'd0,16'h0000, {3'd3,3'd2}, 2'b11, {16'hBBBB,16'hAAAA}, 4'b0000, 0};
        vecs[1]  = '{1,1,0,3'd3,16'hCCCC,1, 1,1,3'd3,16'hDDDD, {3'd5,3'd3}, 2'b11, {16'hBBBB,16'hCCCC}, 4'b0011, 0};
        vecs[2]  = '{1,1,0,3'd3,16'hCCCC,1, 1,1,3'd5,16'hDDDD, {3'd5,3'd3}, 2'b11, {16'hDDDD,16'hCCCC}, 4'b1011, 0};
        vecs[3]  = '{1,0,0,3'd3,16'hCCCC,1, 1,1,3'd3,16'hDDDD, {3'd5,3'd3}, 2'b11, {16'hBBBB,16'hDDDD}, 4'b0010, 0};
        vecs[4]  = '{1,1,0,3'd0,16'h1234,1, 0,0,3'd0,16'h0000, {3'd0,3'd0}, 2'b11, {16'h1234,16'h1234}, 4'b1111, 0};
        vecs[5]  = '{1,1,1,3'd2,16'h5555,0, 0,0,3'd0,16'h0000, {3'd2,3'd1}, 2'b10, {16'h5555,16'hAAAA}, 4'b1100, 1};
        vecs[6]  = '{1,1,1,3'd2,16'h5555,0, 0,0,3'd0,16'h0000, {3'd2,3'd1}, 2'b01, {16'h5555,16'hAAAA}, 4'b1100, 0};
        vecs[7]  = '{1,1,1,3'd2,16'h5555,1, 0,0,3'd0,16'h0000, {3'd2,3'd1}, 2'b10, {16'h5555,16'hAAAA}, 4'b1100, 0};
        vecs[8]  = '{0,1,1,3'd2,16'h5555,0, 0,0,3'd0,16'h0000, {3'd2,3'd1}, 2'b10, {16'hBBBB,16'hAAAA}, 4'b0000, 0};
        vecs[9]  = '{1,0,1,3'd2,16'h5555,0, 1,1,3'd2,16'hDDDD, {3'd2,3'd1}, 2'b10, {16'hDDDD,16'hAAAA}, 4'b1000, 0};
        vecs[10] = '{1,1,1,3'd1,16'h5555,0, 1,1,3'd1,16'hDDDD, {3'd2,3'd1}, 2'b01, {16'hBBBB,16'h5555}, 4'b0011, 1};

        do_reset();
        #1;
        chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        chk("rst_err_tmo", 32'(err_tmo), 32'h0);
        chk("rst_state", 32'(dut.r_state), 32'h0);

        // Operand selection with an empty history
        for (int k = 0; k < 11; k++) begin
            mem_valid = vecs[k].mv; mem_we = vecs[k].mwe; mem_is_load = vecs[k].mld;
            mem_dest = vecs[k].mdst; mem_data = vecs[k].mdata; mem_data_ready = vecs[k].mrdy;
            wb_valid = vecs[k].wv; wb_we = vecs[k].wwe; wb_dest = vecs[k].wdst;
            wb_data = vecs[k].wdata; src_reg = vecs[k].src; src_used = vecs[k].used;
            #1;
            chk($sformatf("vec%0d_opnd", k), opnd, vecs[k].e_opnd);
            chk($sformatf("vec%0d_fwd", k), 32'(fwd_src), 32'(vecs[k].e_fwd));
            chk($sformatf("vec%0d_stall", k), 32'(stall), 32'(vecs[k].e_stall));
            tick();
        end

        // Load-use stall lasting exactly three cycles
        do_reset();
        load_stall_inputs(1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("lu_stall_c%0d", k), 32'(stall), 32'h1);
            chk($sformatf("lu_opnd_c%0d", k), opnd, {16'h5555, 16'hAAAA});
            tick();
        end
        mem_data_ready = 1;
        #1;
        chk("lu_stall_drop", 32'(stall), 32'h0);
        chk("lu_cnt", 32'(stall_cnt), 32'd3);
        chk("lu_state_ld", 32'(dut.r_state), 32'h1);
        tick();
        chk("lu_state_run", 32'(dut.r_state), 32'h0);
        chk("lu_cnt_hold", 32'(stall_cnt), 32'd3);
        chk("lu_no_tmo", 32'(err_tmo), 32'h0);

        // History fill and clear
        do_reset();
        retire(3'd1, 16'h1111, 1'b0);
        retire(3'd4, 16'h4444, 1'b0);
        src_reg = {3'd4, 3'd1}; src_used = 2'b11;
        #1;
        chk("hist_opnd", opnd, {16'h4444, 16'h1111});
        chk("hist_fwd", 32'(fwd_src), 32'h5);
        id_advance = 1;
        tick();
        id_advance = 0;
        #1;
        chk("hist_clr_opnd", opnd, {16'hBBBB, 16'hAAAA});
        chk("hist_clr_fwd", 32'(fwd_src), 32'h0);

        // Overflow evicts the oldest entry; newest duplicate wins
        do_reset();
        retire(3'd1, 16'h0101, 1'b0);
        retire(3'd2, 16'h0202, 1'b0);
        retire(3'd5, 16'h0505, 1'b0);
        src_reg = {3'd2, 3'd1};
        #1;
        chk("ovf_opnd", opnd, {16'h0202, 16'hAAAA});
        chk("ovf_fwd", 32'(fwd_src), 32'h4);
        src_reg = {3'd5, 3'd5};
        #1;
        chk("ovf_r5", opnd, {16'h0505, 16'h0505});
        retire(3'd5, 16'h5A5A, 1'b0);
        #1;
        chk("newest_r5", opnd, {16'h5A5A, 16'h5A5A});
        wb_valid = 1; wb_we = 0; wb_dest = 3'd2; wb_data = 16'h2222; pipe_advance = 1;
        tick();
        wb_valid = 0; pipe_advance = 0;
        src_reg = {3'd2, 3'd5};
        #1;
        chk("nowrite_hold", opnd, {16'hBBBB, 16'h5A5A});
        chk("nowrite_fwd", 32'(fwd_src), 32'h1);

        // Simultaneous accept and retire keeps only the retiring write
        retire(3'd6, 16'h6666, 1'b1);
        src_reg = {3'd5, 3'd6};
        #1;
        chk("simul_opnd", opnd, {16'hBBBB, 16'h6666});
        chk("simul_fwd", 32'(fwd_src), 32'h1);
        chk("simul_hv", 32'(dut.r_hv), 32'h1);

        // Timeout after five stall cycles, sticky until reset
        do_reset();
        load_stall_inputs(1'b0);
        repeat (4) tick();
        chk("tmo_pre", 32'(err_tmo), 32'h0);
        tick();
        chk("tmo_set", 32'(err_tmo), 32'h1);
        chk("tmo_cnt", 32'(stall_cnt), 32'd5);
        mem_data_ready = 1;
        tick();
        tick();
        chk("tmo_sticky", 32'(err_tmo), 32'h1);
        chk("tmo_cnt_hold", 32'(stall_cnt), 32'd5);

        // Counter clear with and without a concurrent stall
        mem_data_ready = 0; cnt_clr = 1;
        tick();
        chk("clr_with_stall", 32'(stall_cnt), 32'd1);
        cnt_clr = 0;
        tick();
        chk("clr_then_inc", 32'(stall_cnt), 32'd2);
        mem_data_ready = 1; cnt_clr = 1;
        tick();
        chk("clr_no_stall", 32'(stall_cnt), 32'd0);
        cnt_clr = 0;

        // Reset during LDSTALL with stall still asserted
        mem_data_ready = 0;
        tick();
        chk("ld_before_rst", 32'(dut.r_state), 32'h1);
        reset = 1;
        tick();
        chk("rst_in_ld_state", 32'(dut.r_state), 32'h0);
        chk("rst_clr_tmo", 32'(err_tmo), 32'h0);
        chk("rst_clr_cnt", 32'(stall_cnt), 32'h0);
        reset = 0;
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
